ysyx_exec_core: RTL and testbench

Execute-stage datapath core for the single-cycle RV32I CPU. It combines three functions: the 32×32 integer register file, the operand-select muxes with the ALU, and the branch comparator. It sits between the instruction decoder and the data-memory interface. Control fields come from the decoder; loaded memory data returns on `dm_data` for write-back.

---
 rtl/ysyx_exec_core.sv | 66 ++++++
 tb/tb_ysyx_exec_core.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ysyx_exec_core.sv
// ysyx_exec_core: RV32I execute datapath; 32x32 register file (async active-low reset, 2 comb reads via inst rs1/rs2, 1 write to inst rd from rf_wr_sel source), operand muxes (alu_a_sel/alu_b_sel) driving the ALU (alu_ctrl -> alu_out), branch compare (br_type -> br_taken) and jump target (jump_addr)
module ysyx_exec_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        rf_wr_en,
  input  logic [1:0]  rf_wr_sel,
  input  logic        alu_a_sel,
  input  logic        alu_b_sel,
  input  logic [3:0]  alu_ctrl,
  input  logic [2:0]  br_type,
  input  logic [31:0] dm_data,
  output logic [31:0] alu_out,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        br_taken,
  output logic [31:0] jump_addr
);
  logic [31:0] rf [1:31];
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [31:0] a, b, wb_data;
  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign a = alu_a_sel ? rs1_data : pc;
  assign b = alu_b_sel ? imm : rs2_data;
  assign shamt = b[4:0];
  always_comb begin
    alu_out = 32'd0;
    case (alu_ctrl)
      4'b0000: alu_out = a + b;
      4'b0001: alu_out = a - b;
      4'b0010: alu_out = a << shamt;
      4'b0011: alu_out = {31'd0, $signed(a) < $signed(b)};
      4'b0100: alu_out = {31'd0, a < b};
      4'b0101: alu_out = a ^ b;
      4'b0110: alu_out = a >> shamt;
      4'b0111: alu_out = $unsigned($signed(a) >>> shamt);
      4'b1000: alu_out = a | b;
      4'b1001: alu_out = a & b;
      4'b1010: alu_out = b;
      default: alu_out = 32'd0;
    endcase
  end
  always_comb
    br_taken = (br_type == 3'b001) ? (rs1_data == rs2_data) :
               (br_type == 3'b010) ? (rs1_data != rs2_data) :
               (br_type == 3'b011) ? ($signed(rs1_data) <  $signed(rs2_data)) :
               (br_type == 3'b100) ? ($signed(rs1_data) >= $signed(rs2_data)) :
               (br_type == 3'b101) ? (rs1_data <  rs2_data) :
               (br_type == 3'b110) ? (rs1_data >= rs2_data) :
               (br_type == 3'b111);
  // JALR clears the target LSB; pc-relative targets pass through
  assign jump_addr = alu_a_sel ? {alu_out[31:1], 1'b0} : alu_out;
  assign wb_data = (rf_wr_sel == 2'b00) ? 32'd0 :
                   (rf_wr_sel == 2'b01) ? pc + 32'd4 :
                   (rf_wr_sel == 2'b10) ? alu_out : dm_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf <= '{default: 32'd0};
    else if (rf_wr_en && rd != 5'd0) rf[rd] <= wb_data;
  end
endmodule

// File: tb/tb_ysyx_exec_core.sv
// tb_ysyx_exec_core: directed self-checking bench for ysyx_exec_core
module tb_ysyx_exec_core;
  logic        clk, rst_n, rf_wr_en, alu_a_sel, alu_b_sel, br_taken;
  logic [31:0] inst, pc, imm, dm_data, alu_out, rs1_data, rs2_data, jump_addr;
  logic [1:0]  rf_wr_sel;
  logic [3:0]  alu_ctrl;
  logic [2:0]  br_type;
  int checks = 0;
  int failures = 0;
  ysyx_exec_core dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .pc(pc), .imm(imm),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .br_type(br_type),
    .dm_data(dm_data), .alu_out(alu_out), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .br_taken(br_taken), .jump_addr(jump_addr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    mk = {7'd0, s2, s1, 3'd0, d, 7'd0};
  endfunction
  task automatic wr(input logic [4:0] d, input logic [31:0] v);
    @(negedge clk);
    inst = mk(d, 5'd0, 5'd0); alu_a_sel = 1'b0; alu_b_sel = 1'b1; imm = v;
    alu_ctrl = 4'b1010; rf_wr_sel = 2'b10; rf_wr_en = 1'b1;
    @(posedge clk); #1;
    rf_wr_en = 1'b0;
  endtask
  task automatic op(input logic [4:0] s1, input logic [4:0] s2, input logic [3:0] c);
    @(negedge clk);
    inst = mk(5'd0, s1, s2); alu_a_sel = 1'b1; alu_b_sel = 1'b0; alu_ctrl = c; rf_wr_en = 1'b0;
    #1;
  endtask
  task automatic br(input logic [2:0] t);
    @(negedge clk);
    inst = mk(5'd0, 5'd1, 5'd3); br_type = t;
    #1;
  endtask
  initial begin
    rst_n = 1'b0; inst = '0; pc = '0; imm = '0; rf_wr_en = 1'b0; rf_wr_sel = 2'b00;
    alu_a_sel = 1'b0; alu_b_sel = 1'b0; alu_ctrl = 4'b0000; br_type = 3'b000; dm_data = '0;
    #1;
    inst = mk(5'd0, 5'd5, 5'd9);
    #1;
    chk("reset_rs1", rs1_data, 32'd0);
    chk("reset_rs2", rs2_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    // ADDI x1,x0,-1
    @(negedge clk);
    inst = mk(5'd1, 5'd0, 5'd0); alu_a_sel = 1'b1; alu_b_sel = 1'b1; imm = 32'hFFFFFFFF;
    alu_ctrl = 4'b0000; rf_wr_sel = 2'b10; rf_wr_en = 1'b1;
    #1;
    chk("addi_alu", alu_out, 32'hFFFFFFFF);
    chk("addi_pre", rs1_data, 32'd0);
    inst = mk(5'd1, 5'd1, 5'd0);
    @(posedge clk); #1;
    chk("addi_x1", rs1_data, 32'hFFFFFFFF);
    @(negedge clk);
    inst = mk(5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    rf_wr_en = 1'b0;
    chk("x0_write", rs1_data, 32'd0);
    wr(5'd2, 32'h80000000);
    wr(5'd3, 32'd1);
    wr(5'd4, 32'd4);
    wr(5'd6, 32'h21);
    op(5'd2, 5'd3, 4'b0011); chk("slt", alu_out, 32'd1);
    op(5'd2, 5'd3, 4'b0100); chk("sltu", alu_out, 32'd0);
    op(5'd2, 5'd4, 4'b0111); chk("sra", alu_out, 32'hF8000000);
    op(5'd2, 5'd4, 4'b0110); chk("srl", alu_out, 32'h08000000);
    op(5'd0, 5'd3, 4'b0001); chk("sub", alu_out, 32'hFFFFFFFF);
    op(5'd2, 5'd6, 4'b0010); chk("sll", alu_out, 32'd0);
    op(5'd3, 5'd6, 4'b0010); chk("sll_mask", alu_out, 32'd2);
    op(5'd1, 5'd6, 4'b0101); chk("xor", alu_out, 32'hFFFFFFDE);
    op(5'd2, 5'd3, 4'b1000); chk("or", alu_out, 32'h80000001);
    op(5'd1, 5'd6, 4'b1001); chk("and", alu_out, 32'h21);
    op(5'd2, 5'd3, 4'b1100); chk("unknown", alu_out, 32'd0);
    op(5'd1, 5'd3, 4'b0000); chk("add_wrap", alu_out, 32'd0);
    br(3'b011); chk("blt", {31'd0, br_taken}, 32'd1);
    br(3'b101); chk("bltu", {31'd0, br_taken}, 32'd0);
    br(3'b110); chk("bgeu", {31'd0, br_taken}, 32'd1);
    br(3'b001); chk("beq", {31'd0, br_taken}, 32'd0);
    br(3'b010); chk("bne", {31'd0, br_taken}, 32'd1);
    br(3'b100); chk("bge", {31'd0, br_taken}, 32'd0);
    br(3'b111); chk("always", {31'd0, br_taken}, 32'd1);
    br(3'b000); chk("never", {31'd0, br_taken}, 32'd0);
    // JALR x9, 4(x8)
    wr(5'd8, 32'h80000003);
    @(negedge clk);
    inst = mk(5'd9, 5'd8, 5'd0); pc = 32'h80000100; imm = 32'd4; alu_a_sel = 1'b1;
    alu_b_sel = 1'b1; alu_ctrl = 4'b0000; rf_wr_sel = 2'b01; rf_wr_en = 1'b1;
    #1;
    chk("jalr_target", jump_addr, 32'h80000006);
    inst = mk(5'd9, 5'd9, 5'd0);
    @(posedge clk); #1;
    rf_wr_en = 1'b0;
    chk("jalr_link", rs1_data, 32'h80000104);
    @(negedge clk);
    pc = 32'h100; imm = 32'd5; alu_a_sel = 1'b0;
    #1;
    chk("jal_target", jump_addr, 32'h105);
    // load into x7 with same-cycle read
    wr(5'd7, 32'h1234);
    @(negedge clk);
    inst = mk(5'd7, 5'd7, 5'd7); rf_wr_sel = 2'b11; dm_data = 32'hFFFFFF80; rf_wr_en = 1'b1;
    #1;
    chk("load_old", rs1_data, 32'h1234);
    @(posedge clk); #1;
    rf_wr_en = 1'b0;
    chk("load_new", rs2_data, 32'hFFFFFF80);
    @(negedge clk);
    rf_wr_sel = 2'b00; rf_wr_en = 1'b1;
    @(posedge clk); #1;
    rf_wr_en = 1'b0;
    chk("wb_zero", rs1_data, 32'd0);
    // asynchronous reset mid-run
    wr(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    inst = mk(5'd0, 5'd5, 5'd1);
    #1;
    chk("x5_set", rs1_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_x5", rs1_data, 32'd0);
    chk("async_rst_x1", rs2_data, 32'd0);
    inst = mk(5'd5, 5'd5, 5'd0); alu_a_sel = 1'b0; alu_b_sel = 1'b1; imm = 32'h55;
    alu_ctrl = 4'b1010; rf_wr_sel = 2'b10; rf_wr_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_write", rs1_data, 32'd0);
    chk("rst_alu_live", alu_out, 32'h55);
    rf_wr_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
